dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Multi-cycle data-memory responder: the target side of the pipeline's MEM-stage load/store interface.
- Accepts one word read or write request at a time and completes it after a fixed, parameterised latency.
- Pulses `ack_o` for one cycle when the request completes.
- Drives `stall_o` so the pipeline freezes while a request is outstanding.
- Replaces the single-cycle data memory in the cached/off-chip configuration.

Parameters:
- LATENCY, 10: cycles from request acceptance to ack; legal range 1..255.
- ADDR_BITS, 10: word-index width; storage depth is 2**ADDR_BITS words of 32 bits.

Ports:
- clk_i  input  1  clock; rising edge active.
- rst_i  input  1  reset; asynchronous, active-low.
- req_i  input  1  request valid; held high by the requester until `ack_o`.
- we_i  input  1  1 = write (store), 0 = read (load); sampled with `req_i`.
- addr_i  input  32  byte address; word index = addr_i[ADDR_BITS+1:2].
- wdata_i  input  32  store data; sampled with `req_i`.
- rdata_o  output  32  load data; valid while `ack_o` is high and held afterwards.
- ack_o  output  1  one-cycle completion pulse.
- stall_o  output  1  combinational: req_i & ~ack_o.

Behaviour:
- Reset (rst_i low, asynchronous):
  - state = IDLE, counter = 0, ack_o = 0, rdata_o = 0.
  - Storage array is not cleared.
  - Reset mid-request aborts it; no write occurs unless the access edge has already passed.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Rising edge with req_i = 1: capture we_i, word index and wdata_i into internal registers.
  - Load counter = LATENCY-1 and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Captured fields are used; req_i/we_i/addr_i/wdata_i changes are ignored.
  - counter != 0: decrement at each edge.
  - counter == 0 at an edge (the access edge):
    - if write, mem[idx] <= wdata; rdata_o unchanged;
    - if read, rdata_o <= mem[idx];
    - go to DONE.
- DONE:
  - ack_o = 1 for exactly this cycle.
  - Next edge goes to IDLE unconditionally.
  - A request still high in DONE is not re-accepted in DONE. It is accepted at the following IDLE edge and treated as a new request.
- Latency:
  - Request accepted at edge N → access at edge N+LATENCY → ack_o high for the cycle following edge N+LATENCY.
  - LATENCY=1: ack in the cycle right after the accept-edge's following edge; one BUSY cycle minimum.
- Throughput: back-to-back requests are spaced LATENCY+2 cycles apart (IDLE, BUSY×LATENCY, DONE).
- stall_o:
  - High whenever req_i is high and ack_o is low, including the IDLE cycle in which the request is first presented.
  - Low in the ack cycle, so the pipeline advances on the same edge that leaves DONE.
- Addressing:
  - addr_i[1:0] is ignored (word access only).
  - Bits above ADDR_BITS+1 are ignored; addresses alias modulo depth.
- Read-after-write to the same word in consecutive requests returns the new data; the write completes before the next request can be accepted.
- ack_o and rdata_o are registered outputs, with no combinational path from inputs. stall_o is the only combinational output.
- req_i low while BUSY (requester protocol violation): the request still completes and acks; no error flag.

Test Plan:
- Reset, then check: rst_i low 3 cycles → ack_o=0, rdata_o=0x00000000, stall_o=0 with req_i=0.
- Write then read (LATENCY=4):
  - write req addr 0x00000010, data 0xDEADBEEF → stall_o high 5 cycles, ack_o pulse exactly 1 cycle, 4 cycles after accept edge.
  - read req addr 0x00000010 → ack with rdata_o=0xDEADBEEF.
- Field capture: during BUSY of a read at 0x20 (mem=0x12345678), change addr_i to 0x24 and we_i to 1 → ack with rdata_o=0x12345678 and mem[0x24] unchanged.
- Aliasing and low bits (ADDR_BITS=10): write 0xA5A5A5A5 to 0x00001003 → read of 0x00000000 returns 0xA5A5A5A5.
- Reset mid-op: write req 0x40 data 0x11111111, assert rst_i low 2 cycles into BUSY → no ack; a later read of 0x40 returns the prior contents (preloaded 0x0).
- LATENCY=1 and back-to-back:
  - hold req_i high across two reads → acks spaced exactly 3 cycles apart;
  - rdata_o updates only on the access edges;
  - stall_o drops only in the ack cycles.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM-stage load/store port.
// One word request is accepted at a time and completes LATENCY edges after
// acceptance. ack_o pulses for one cycle on completion, and stall_o holds
// the pipeline while a request is outstanding.
module dmem_responder #(
    parameter int LATENCY   = 10,  // 1..255
    parameter int ADDR_BITS = 10
) (
    input  logic        clk_i,
    input  logic        rst_i,     // asynchronous, active-low
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        stall_o
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   we_q;
    logic [ADDR_BITS-1:0]   idx_q;
    logic [31:0]            wdata_q;
    logic [31:0]            rdata_q;
    logic                   ack_q, ack_d;
    logic                   capture_en;
    logic                   access_en;

    logic [31:0]            mem [DEPTH];

    // Byte-lane bits and bits above the word index are ignored; addresses
    // alias modulo the storage depth.
    logic                   unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[31:ADDR_BITS+2], addr_i[1:0]};

    // Next-state, counter and strobe decode for the request FSM
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        capture_en = 1'b0;
        access_en  = 1'b0;
        ack_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    capture_en = 1'b1;
                    cnt_d      = 8'(LATENCY - 1);
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                // Inputs are ignored here; only the captured fields matter.
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    access_en = 1'b1;
                    ack_d     = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                // A still-high request is picked up on the following IDLE edge.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, captured request fields and ack register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            if (capture_en) begin
                we_q    <= we_i;
                idx_q   <= addr_i[ADDR_BITS+1:2];
                wdata_q <= wdata_i;
            end
        end
    end

    // Storage write on the access edge; contents survive reset
    always_ff @(posedge clk_i) begin
        if (access_en && we_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    // Registered load data, updated only on a read's access edge and held after
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_q <= 32'd0;
        end else if (access_en && !we_q) begin
            rdata_q <= mem[idx_q];
        end
    end

    assign rdata_o = rdata_q;
    assign ack_o   = ack_q;
    assign stall_o = req_i & ~ack_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: one instance at
// LATENCY=4 and one at LATENCY=1, sharing clock, reset and request fields.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        sel;       // 0 = LATENCY 4 instance, 1 = LATENCY 1 instance
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic        req4, req1;
    logic [31:0] rdata4, rdata1;
    logic        ack4, ack1;
    logic        stall4, stall1;

    logic [31:0] rdata_m;
    logic        ack_m;
    logic        stall_m;

    int n_tests = 0;
    int n_fail  = 0;

    assign req4    = req & ~sel;
    assign req1    = req & sel;
    assign rdata_m = sel ? rdata1 : rdata4;
    assign ack_m   = sel ? ack1 : ack4;
    assign stall_m = sel ? stall1 : stall4;

    dmem_responder #(.LATENCY(4), .ADDR_BITS(10)) u_dut4 (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .req_i   (req4),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
        .rdata_o (rdata4),
        .ack_o   (ack4),
        .stall_o (stall4)
    );

    dmem_responder #(.LATENCY(1), .ADDR_BITS(10)) u_dut1 (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .req_i   (req1),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
        .rdata_o (rdata1),
        .ack_o   (ack1),
        .stall_o (stall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full request. lat = edges from accept edge to the ack cycle,
    // stalls = cycles with stall high. mutate changes the request fields
    // right after the accept edge. Returns one cycle after ack with req low.
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input bit mutate, output logic [31:0] rd,
                       output int lat, output int stalls);
        we = w; addr = a; wdata = d; req = 1'b1;
        #1;
        lat = -1; stalls = 0; rd = 32'hxxxxxxxx;
        for (int c = 0; c < 40; c++) begin
            if (stall_m) stalls++;
            if (ack_m) begin
                lat = c - 1;
                rd  = rdata_m;
                break;
            end
            step();
            if (mutate && c == 0) begin
                addr  = a + 32'd4;
                we    = ~w;
                wdata = 32'hFFFF0000;
            end
        end
        req = 1'b0;
        $display("[TB] txn L%0d we=%0d addr=0x%08h wdata=0x%08h rdata=0x%08h lat=%0d stalls=%0d",
                 sel ? 1 : 4, w, a, d, rd, lat, stalls);
        step();
    endtask

    logic [31:0] rd;
    int          lat, stalls;
    int          ack_count;
    int          ack_at [2];
    int          n_ack;
    int          cyc;
    logic        exp_ack   [7];
    logic        exp_stall [7];
    logic [31:0] exp_rdata [7];

    initial begin
        rst_n = 1'b1; req = 1'b0; sel = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
        #2 rst_n = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack4",   32'(ack4),   32'd0);
        check("rst_rdata4", rdata4,      32'd0);
        check("rst_stall4", 32'(stall4), 32'd0);
        check("rst_ack1",   32'(ack1),   32'd0);
        check("rst_rdata1", rdata1,      32'd0);
        rst_n = 1'b1;
        step();

        // Write then read, LATENCY 4
        txn(1'b1, 32'h00000010, 32'hDEADBEEF, 1'b0, rd, lat, stalls);
        check("wr_lat",        32'(lat),    32'd4);
        check("wr_stalls",     32'(stalls), 32'd5);
        check("wr_ack_pulse",  32'(ack_m),  32'd0);
        check("wr_rdata_kept", rdata_m,     32'd0);
        txn(1'b0, 32'h00000010, 32'h0, 1'b0, rd, lat, stalls);
        check("rd_data",       rd,          32'hDEADBEEF);
        check("rd_lat",        32'(lat),    32'd4);
        check("rd_stalls",     32'(stalls), 32'd5);
        check("rd_ack_pulse",  32'(ack_m),  32'd0);
        check("rd_rdata_held", rdata_m,     32'hDEADBEEF);

        // Field capture: inputs changed during BUSY are ignored
        txn(1'b1, 32'h00000024, 32'h0BADF00D, 1'b0, rd, lat, stalls);
        txn(1'b1, 32'h00000020, 32'h12345678, 1'b0, rd, lat, stalls);
        txn(1'b0, 32'h00000020, 32'h0, 1'b1, rd, lat, stalls);
        check("cap_rdata",     rd,          32'h12345678);
        check("cap_lat",       32'(lat),    32'd4);
        txn(1'b0, 32'h00000024, 32'h0, 1'b0, rd, lat, stalls);
        check("cap_mem24",     rd,          32'h0BADF00D);

        // Aliasing and ignored byte bits
        txn(1'b1, 32'h00001003, 32'hA5A5A5A5, 1'b0, rd, lat, stalls);
        txn(1'b0, 32'h00000000, 32'h0, 1'b0, rd, lat, stalls);
        check("alias_rdata",   rd,          32'hA5A5A5A5);

        // Requester drops req during BUSY: still completes
        we = 1'b0; addr = 32'h00000010; req = 1'b1;
        step();
        req = 1'b0;
        lat = -1;
        for (int c = 1; c < 40; c++) begin
            if (ack_m) begin
                lat = c - 1;
                break;
            end
            step();
        end
        $display("[TB] txn L4 read 0x00000010 with req dropped in BUSY lat=%0d rdata=0x%08h", lat, rdata_m);
        check("drop_lat",      32'(lat),    32'd4);
        check("drop_rdata",    rdata_m,     32'hDEADBEEF);
        step();

        // Reset mid-op aborts the write
        txn(1'b1, 32'h00000040, 32'h00000000, 1'b0, rd, lat, stalls);
        we = 1'b1; addr = 32'h00000040; wdata = 32'h11111111; req = 1'b1;
        step();           // accept edge
        step();           // first decrement edge
        rst_n = 1'b0; req = 1'b0;
        #1;
        check("mid_rst_ack",   32'(ack_m),  32'd0);
        check("mid_rst_rdata", rdata_m,     32'd0);
        step();
        step();
        rst_n = 1'b1;
        ack_count = 0;
        for (int c = 0; c < 8; c++) begin
            if (ack_m) ack_count++;
            step();
        end
        $display("[TB] txn L4 write 0x00000040 aborted by reset, acks seen=%0d", ack_count);
        check("mid_rst_noack", 32'(ack_count), 32'd0);
        txn(1'b0, 32'h00000040, 32'h0, 1'b0, rd, lat, stalls);
        check("mid_rst_mem",   rd,          32'h00000000);

        // LATENCY 1, back-to-back reads with req held high
        sel = 1'b1;
        #1;
        txn(1'b1, 32'h00000100, 32'hCAFEBABE, 1'b0, rd, lat, stalls);
        check("l1_wr_lat",     32'(lat),    32'd1);
        check("l1_wr_stalls",  32'(stalls), 32'd2);
        txn(1'b1, 32'h00000104, 32'h55AA55AA, 1'b0, rd, lat, stalls);
        check("l1_rdata_init", rdata_m,     32'd0);

        exp_ack   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_stall = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_rdata = '{32'h0, 32'h0, 32'hCAFEBABE, 32'hCAFEBABE, 32'hCAFEBABE,
                      32'h55AA55AA, 32'h55AA55AA};
        we = 1'b0; addr = 32'h00000100; req = 1'b1;
        #1;
        n_ack = 0;
        ack_at[0] = -1; ack_at[1] = -1;
        for (cyc = 0; cyc < 7; cyc++) begin
            check($sformatf("b2b_ack_c%0d", cyc),   32'(ack_m),   32'(exp_ack[cyc]));
            check($sformatf("b2b_stall_c%0d", cyc), 32'(stall_m), 32'(exp_stall[cyc]));
            check($sformatf("b2b_rdata_c%0d", cyc), rdata_m,      exp_rdata[cyc]);
            if (ack_m && n_ack < 2) begin
                ack_at[n_ack] = cyc;
                n_ack++;
            end
            if (cyc == 2) addr = 32'h00000104;
            if (cyc == 5) req = 1'b0;
            step();
        end
        $display("[TB] txn L1 back-to-back reads acks at cycles %0d and %0d", ack_at[0], ack_at[1]);
        check("b2b_spacing", 32'(ack_at[1] - ack_at[0]), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
